// File: rtl/pc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// pc_fetch_sequencer
//
// Fetch-stage controller. Owns the PC register and sequences it against the
// instruction memory port. At most one fetch is outstanding at any time: a
// request is presented on a valid/ready channel, then the sequencer waits for
// the response. A completed fetch either delivers the instruction and advances
// the PC by INC, or (when a redirect arrived while the fetch was in flight) is
// discarded while the PC is loaded with the redirect target.
//
// Optional feature macro: PC_MISALIGN_TRAP_EN
//   defined   : a redirect whose target[1:0] != 0 is not taken; the PC is
//               loaded with TRAP_VEC and misalign_trap pulses for one cycle.
//   undefined : target[1:0] is forced to 2'b00 and misalign_trap is tied 0.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   stall, halt       level requests, honoured when the current fetch is done
//   br_taken          single-cycle redirect strobe, br_target is its target
//   if_req_valid/addr fetch request towards memory; if_req_ready accepts it
//   if_rsp_valid      memory response strobe; if_rsp_instr is its data
//   instr_valid       one-cycle pulse; instr / instr_pc describe the fetch
//   pc_out            current PC
//   state             IDLE=0, REQ=1, WAIT=2, HOLD=3, HALT=4
//   misalign_trap     one-cycle pulse on a rejected misaligned redirect
// -----------------------------------------------------------------------------
module pc_fetch_sequencer #(
  parameter int unsigned     PC_W      = 64,
  parameter logic [PC_W-1:0] RESET_VEC = {PC_W{1'b0}},
  parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'(64'h100),
  parameter int unsigned     INC       = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            halt,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  output logic            if_req_valid,
  output logic [PC_W-1:0] if_req_addr,
  input  logic            if_req_ready,
  input  logic            if_rsp_valid,
  input  logic [31:0]     if_rsp_instr,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [PC_W-1:0] instr_pc,
  output logic [PC_W-1:0] pc_out,
  output logic [2:0]      state,
  output logic            misalign_trap
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_HALT = 3'd4
  } state_t;

  // Turns a raw redirect target into the PC value actually loaded.
  function automatic logic [PC_W-1:0] land_pc(input logic [PC_W-1:0] tgt);
    logic [PC_W-1:0] v;
`ifdef PC_MISALIGN_TRAP_EN
    if (tgt[1:0] != 2'b00) begin
      v = TRAP_VEC;
    end else begin
      v = tgt;
    end
`else
    v      = tgt;
    v[1:0] = 2'b00;
`endif
    return v;
  endfunction

`ifdef PC_MISALIGN_TRAP_EN
  // True when a redirect target is not word aligned.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction
`endif

  // Registered state and outputs
  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_pend;
  logic [PC_W-1:0] r_pend_tgt;
  logic            r_req_valid;
  logic [PC_W-1:0] r_req_addr;
  logic            r_instr_valid;
  logic [31:0]     r_instr;
  logic [PC_W-1:0] r_instr_pc;

  // Next-state values
  state_t          w_nxt_state;
  logic [PC_W-1:0] w_nxt_pc;
  logic            w_nxt_pend;
  logic [PC_W-1:0] w_nxt_pend_tgt;
  logic            w_use_br;    // live br_target is loaded into the PC now
  logic            w_use_pend;  // latched pending target is loaded now
  logic            w_deliver;   // completed fetch is handed to decode
  logic [PC_W-1:0] w_br_pc;
  logic [PC_W-1:0] w_pend_pc;

  assign w_br_pc   = land_pc(br_target);
  assign w_pend_pc = land_pc(r_pend_tgt);

  // Sequencing rules: state transitions, pending redirect and PC source.
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_pend     = r_pend;
    w_nxt_pend_tgt = r_pend_tgt;
    w_use_br       = 1'b0;
    w_use_pend     = 1'b0;
    w_deliver      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // No fetch in flight: a redirect lands on the PC directly.
        w_use_br = br_taken;
        if (halt) begin
          w_nxt_state = S_HALT;
        end else begin
          w_nxt_state = S_REQ;
        end
      end
      S_REQ: begin
        // The fetch is committed once requested; a redirect waits for it.
        if (br_taken) begin
          w_nxt_pend     = 1'b1;
          w_nxt_pend_tgt = br_target;
        end else begin
          w_nxt_pend     = r_pend;
          w_nxt_pend_tgt = r_pend_tgt;
        end
        if (if_req_ready) begin
          w_nxt_state = S_WAIT;
        end else begin
          w_nxt_state = S_REQ;
        end
      end
      S_WAIT: begin
        if (if_rsp_valid) begin
          // A same-cycle redirect beats an older pending one.
          if (br_taken) begin
            w_use_br = 1'b1;
          end else if (r_pend) begin
            w_use_pend = 1'b1;
          end else begin
            w_deliver = 1'b1;
          end
          w_nxt_pend     = 1'b0;
          w_nxt_pend_tgt = r_pend_tgt;
          if (halt) begin
            w_nxt_state = S_HALT;
          end else if (stall) begin
            w_nxt_state = S_HOLD;
          end else begin
            w_nxt_state = S_REQ;
          end
        end else begin
          if (br_taken) begin
            w_nxt_pend     = 1'b1;
            w_nxt_pend_tgt = br_target;
          end else begin
            w_nxt_pend     = r_pend;
            w_nxt_pend_tgt = r_pend_tgt;
          end
          w_nxt_state = S_WAIT;
        end
      end
      S_HOLD: begin
        w_use_br = br_taken;
        if (halt) begin
          w_nxt_state = S_HALT;
        end else if (stall) begin
          w_nxt_state = S_HOLD;
        end else begin
          w_nxt_state = S_REQ;
        end
      end
      S_HALT: begin
        w_use_br = br_taken;
        if (halt) begin
          w_nxt_state = S_HALT;
        end else begin
          w_nxt_state = S_REQ;
        end
      end
      default: begin
        // Unreachable encoding: recover through IDLE with nothing pending.
        w_nxt_state    = S_IDLE;
        w_nxt_pend     = 1'b0;
        w_nxt_pend_tgt = r_pend_tgt;
      end
    endcase
  end

  // PC source mux; increment wraps naturally at 2^PC_W.
  always_comb begin
    if (w_use_br) begin
      w_nxt_pc = w_br_pc;
    end else if (w_use_pend) begin
      w_nxt_pc = w_pend_pc;
    end else if (w_deliver) begin
      w_nxt_pc = r_pc + PC_W'(INC);
    end else begin
      w_nxt_pc = r_pc;
    end
  end

  // Sequencer state, PC and registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_VEC;
      r_pend        <= 1'b0;
      r_pend_tgt    <= {PC_W{1'b0}};
      r_req_valid   <= 1'b0;
      r_req_addr    <= {PC_W{1'b0}};
      r_instr_valid <= 1'b0;
      r_instr       <= 32'h0;
      r_instr_pc    <= {PC_W{1'b0}};
    end else begin
      r_state       <= w_nxt_state;
      r_pc          <= w_nxt_pc;
      r_pend        <= w_nxt_pend;
      r_pend_tgt    <= w_nxt_pend_tgt;
      // The request is raised with the PC it will carry, so a redirect that
      // lands on the same edge is what gets fetched.
      r_req_valid   <= (w_nxt_state == S_REQ);
      if (w_nxt_state == S_REQ) begin
        r_req_addr <= w_nxt_pc;
      end else begin
        r_req_addr <= r_req_addr;
      end
      r_instr_valid <= w_deliver;
      if (w_deliver) begin
        r_instr    <= if_rsp_instr;
        r_instr_pc <= r_pc;
      end else begin
        r_instr    <= r_instr;
        r_instr_pc <= r_instr_pc;
      end
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic r_trap;
  logic w_nxt_trap;

  assign w_nxt_trap = (w_use_br   & is_misaligned(br_target[1:0])) |
                      (w_use_pend & is_misaligned(r_pend_tgt[1:0]));

  // Trap pulse, raised on the edge the rejected redirect is applied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trap <= 1'b0;
    end else begin
      r_trap <= w_nxt_trap;
    end
  end

  assign misalign_trap = r_trap;
`else
  // TRAP_VEC only matters when the trap feature is built in.
  logic w_unused_trap;
  assign w_unused_trap = ^TRAP_VEC;
  assign misalign_trap = 1'b0;
`endif

  assign state        = r_state;
  assign pc_out       = r_pc;
  assign if_req_valid = r_req_valid;
  assign if_req_addr  = r_req_addr;
  assign instr_valid  = r_instr_valid;
  assign instr        = r_instr;
  assign instr_pc     = r_instr_pc;

endmodule
